// File: rtl/dmem_pkg.sv
// Shared types, defaults and helpers for the data-memory arbiter.
// Imported by the arbiter top and its memory-bus interface users.
package dmem_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_WAIT,
        S_HALT
    } state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_BLOCK_W    = 512;
    localparam int DEF_ALIGN_BITS = 7;

    // Clears the low 'bits' address bits; callers size to their width.
    function automatic logic [63:0] align_addr(
        input logic [63:0] a,
        input int          bits
    );
        logic [63:0] r;
        r = a;
        for (int i = 0; i < 64; i++) begin
            if (i < bits) begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus between the arbiter and the shared block data memory.
// The arbiter is the master; the memory is the slave.
interface dmem_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 512
);

    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_readable;
    logic               mem_writable;
    logic [BLOCK_W-1:0] mem_write;
    logic [BLOCK_W-1:0] mem_out1;
    logic [BLOCK_W-1:0] mem_out2;
    logic               mem_flush;

    modport master (
        output mem_addr,
        output mem_readable,
        output mem_writable,
        output mem_write,
        output mem_flush,
        input  mem_out1,
        input  mem_out2
    );

    modport slave (
        input  mem_addr,
        input  mem_readable,
        input  mem_writable,
        input  mem_write,
        input  mem_flush,
        output mem_out1,
        output mem_out2
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
// The last-grant pointer is held by the parent.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt
);

    // On a conflict the port not granted last wins.
    always_comb begin
        o_gnt = 2'b00;
        if (i_req[0] && i_req[1]) begin
            o_gnt = i_last ? 2'b01 : 2'b10;
        end else begin
            o_gnt = i_req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Sequences the shared block memory for icache and dcache ports.
// Round-robin grant, optional writeback, two-block read, halt flush.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int BLOCK_W    = DEF_BLOCK_W,
    parameter int ALIGN_BITS = DEF_ALIGN_BITS,
    parameter int LAT        = 1
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0,
    input  logic [ADDR_W-1:0]  addr0,

    input  logic               req1,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic               wb1,
    input  logic [ADDR_W-1:0]  wb_addr1,
    input  logic [BLOCK_W-1:0] wdata1,

    output logic               done0,
    output logic               done1,
    output logic [BLOCK_W-1:0] rdata_lo,
    output logic [BLOCK_W-1:0] rdata_hi,

    input  logic               halt_req,
    output logic               halted,

    dmem_arbiter_if.master     mem
);

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t             r_state;
    state_t             w_next;

    logic               r_gnt;
    logic               r_ptr;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  r_wb_addr;
    logic [BLOCK_W-1:0] r_wdata;
    logic [3:0]         r_cnt;

    logic               w_el0;
    logic               w_el1;
    logic [1:0]         w_gnt;
    logic               w_take;
    logic               w_cap;
    logic [ADDR_W-1:0]  w_rd_al;
    logic [ADDR_W-1:0]  w_wb_al;

    // A port still showing its done pulse holds a stale request.
    assign w_el0 = req0 & ~done0;
    assign w_el1 = req1 & ~done1;

    assign w_rd_al = ADDR_W'(align_addr(64'(r_addr), ALIGN_BITS));
    assign w_wb_al = ADDR_W'(align_addr(64'(r_wb_addr), ALIGN_BITS));

    rr_arb2 u_arb (
        .i_req  ({w_el1, w_el0}),
        .i_last (r_ptr),
        .o_gnt  (w_gnt)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and Moore memory controls.
    always_comb begin
        w_next           = r_state;
        w_take           = 1'b0;
        w_cap            = 1'b0;
        mem.mem_addr     = '0;
        mem.mem_readable = 1'b0;
        mem.mem_writable = 1'b0;
        mem.mem_write    = '0;
        mem.mem_flush    = 1'b0;
        halted           = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (halt_req) begin
                    w_next = S_HALT;
                end else if (|w_gnt) begin
                    w_take = 1'b1;
                    if (w_gnt[1] && wb1) begin
                        w_next = S_WRITE;
                    end else begin
                        w_next = S_READ;
                    end
                end
            end
            S_WRITE: begin
                mem.mem_writable = 1'b1;
                mem.mem_addr     = w_wb_al;
                mem.mem_write    = r_wdata;
                w_next           = S_READ;
            end
            S_READ: begin
                mem.mem_readable = 1'b1;
                mem.mem_addr     = w_rd_al;
                w_next           = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_cap  = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_HALT: begin
                mem.mem_flush = 1'b1;
                halted        = 1'b1;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Capture the granted request so later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt     <= 1'b0;
            r_ptr     <= 1'b1;
            r_addr    <= '0;
            r_wb_addr <= '0;
            r_wdata   <= '0;
        end else if (w_take) begin
            r_gnt     <= w_gnt[1];
            r_ptr     <= w_gnt[1];
            r_addr    <= w_gnt[1] ? addr1 : addr0;
            r_wb_addr <= wb_addr1;
            r_wdata   <= wdata1;
        end
    end

    // Wait counter: loaded in READ, counts down through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == S_READ) begin
            r_cnt <= CNT_INIT;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Read data capture and one-cycle completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done0    <= 1'b0;
            done1    <= 1'b0;
            rdata_lo <= '0;
            rdata_hi <= '0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (w_cap) begin
                rdata_lo <= mem.mem_out1;
                rdata_hi <= mem.mem_out2;
                done0    <= ~r_gnt;
                done1    <= r_gnt;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: vector table, scoreboard of completions,
// and hand sequences for round-robin, long latency, halt and reset.
module tb_dmem_arbiter;

    typedef struct {
        logic         port;
        logic         wb;
        logic [31:0]  addr;
        logic [31:0]  wb_addr;
        logic [511:0] wdata;
        logic [31:0]  exp_addr;
        logic [31:0]  exp_wb;
        int           lat;
        logic [511:0] lo;
        logic [511:0] hi;
    } vec_t;

    typedef struct {
        logic         port;
        logic [511:0] lo;
        logic [511:0] hi;
    } sb_t;

    logic         clk;
    logic         rst_n;
    logic         req0, req1, wb1, halt_req;
    logic [31:0]  addr0, addr1, wb_addr1;
    logic [511:0] wdata1;
    logic         done0, done1, halted;
    logic [511:0] rdata_lo, rdata_hi;

    logic         r4_req0;
    logic [31:0]  r4_addr0;
    logic         d4_done0, d4_done1, d4_halted;
    logic [511:0] d4_lo, d4_hi;

    int n_checks = 0;
    int n_err    = 0;
    int n_done   = 0;
    sb_t sb[$];
    logic [511:0] lo_mem [logic [31:0]];

    dmem_arbiter_if #(.ADDR_W(32), .BLOCK_W(512)) mif ();
    dmem_arbiter_if #(.ADDR_W(32), .BLOCK_W(512)) mif4 ();

    dmem_arbiter #(
        .ADDR_W(32), .BLOCK_W(512), .ALIGN_BITS(7), .LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0),
        .req1(req1), .addr1(addr1), .wb1(wb1),
        .wb_addr1(wb_addr1), .wdata1(wdata1),
        .done0(done0), .done1(done1),
        .rdata_lo(rdata_lo), .rdata_hi(rdata_hi),
        .halt_req(halt_req), .halted(halted),
        .mem(mif)
    );

    dmem_arbiter #(
        .ADDR_W(32), .BLOCK_W(512), .ALIGN_BITS(7), .LAT(4)
    ) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req0(r4_req0), .addr0(r4_addr0),
        .req1(1'b0), .addr1(32'h0), .wb1(1'b0),
        .wb_addr1(32'h0), .wdata1(512'h0),
        .done0(d4_done0), .done1(d4_done1),
        .rdata_lo(d4_lo), .rdata_hi(d4_hi),
        .halt_req(1'b0), .halted(d4_halted),
        .mem(mif4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] pat(input logic [31:0] a, input bit h);
        return {16{a ^ (h ? 32'hC3C3_0000 : 32'h0000_3C3C)}};
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Memory model: one-cycle registered read, block write to low half.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mif.mem_out1 <= '0;
            mif.mem_out2 <= '0;
        end else begin
            if (mif.mem_writable) lo_mem[mif.mem_addr] = mif.mem_write;
            if (mif.mem_readable) begin
                if (lo_mem.exists(mif.mem_addr)) mif.mem_out1 <= lo_mem[mif.mem_addr];
                else mif.mem_out1 <= pat(mif.mem_addr, 1'b0);
                mif.mem_out2 <= pat(mif.mem_addr, 1'b1);
            end
        end
    end

    // Completion monitor: every done pops and checks the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("strobe_excl", mif.mem_readable & mif.mem_writable, 0);
            if (done0 || done1) begin
                n_done++;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none", done0, done1);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_onehot", done0 & done1, 0);
                    chk("sb_port", done1, e.port);
                    chk("sb_lo", rdata_lo, e.lo);
                    chk("sb_hi", rdata_hi, e.hi);
                end
            end
        end
    end

    task automatic check_zero(input string p);
        chk({p, "_done0"}, done0, 0);
        chk({p, "_done1"}, done1, 0);
        chk({p, "_rlo"}, rdata_lo, 0);
        chk({p, "_rhi"}, rdata_hi, 0);
        chk({p, "_addr"}, mif.mem_addr, 0);
        chk({p, "_rd"}, mif.mem_readable, 0);
        chk({p, "_wr"}, mif.mem_writable, 0);
        chk({p, "_wdata"}, mif.mem_write, 0);
        chk({p, "_flush"}, mif.mem_flush, 0);
        chk({p, "_halted"}, halted, 0);
    endtask

    task automatic do_txn(input vec_t v, input string nm);
        int lat;
        lat = 0;
        sb.push_back('{port: v.port, lo: v.lo, hi: v.hi});
        if (v.port == 1'b0) begin
            req0 = 1'b1;
            addr0 = v.addr;
        end else begin
            req1 = 1'b1;
            addr1 = v.addr;
            wb1 = v.wb;
            wb_addr1 = v.wb_addr;
            wdata1 = v.wdata;
        end
        @(posedge clk);
        #1;
        addr0 = $urandom;
        addr1 = $urandom;
        wb_addr1 = $urandom;
        wdata1 = {16{$urandom}};
        wb1 = 1'($urandom);
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            if (v.wb && cyc == 1) begin
                chk({nm, "_wr"}, mif.mem_writable, 1);
                chk({nm, "_wr_addr"}, mif.mem_addr, v.exp_wb);
                chk({nm, "_wr_data"}, mif.mem_write, v.wdata);
            end
            if (cyc == (v.wb ? 2 : 1)) begin
                chk({nm, "_rd"}, mif.mem_readable, 1);
                chk({nm, "_rd_wr"}, mif.mem_writable, 0);
                chk({nm, "_rd_addr"}, mif.mem_addr, v.exp_addr);
            end
            if (done0 || done1) begin
                lat = cyc;
                req0 = 1'b0;
                req1 = 1'b0;
                break;
            end
        end
        chk({nm, "_latency"}, lat, v.lat);
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(
        input logic p, input logic w, input logic [31:0] a,
        input logic [31:0] wa, input logic [511:0] wd,
        input logic [31:0] ea, input logic [31:0] ew, input int l,
        input logic [511:0] lo, input logic [511:0] hi
    );
        vec_t v;
        v.port = p; v.wb = w; v.addr = a; v.wb_addr = wa; v.wdata = wd;
        v.exp_addr = ea; v.exp_wb = ew; v.lat = l; v.lo = lo; v.hi = hi;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        logic [511:0] pa, pb;
        int n_start, c_end;
        pa = {8{64'hDEAD_BEEF_0123_4567}};
        pb = {16{32'h5A5A_F00D}};
        vecs[0] = mkv(0, 0, 32'h1234_5678, 0, 0, 32'h1234_5600, 0, 3,
                      pat(32'h1234_5600, 0), pat(32'h1234_5600, 1));
        vecs[1] = mkv(1, 1, 32'h400, 32'h200, pa, 32'h400, 32'h200, 4,
                      pat(32'h400, 0), pat(32'h400, 1));
        vecs[2] = mkv(1, 0, 32'h200, 0, 0, 32'h200, 0, 3, pa, pat(32'h200, 1));
        vecs[3] = mkv(0, 0, 32'h7F, 0, 0, 32'h0, 0, 3, pat(32'h0, 0), pat(32'h0, 1));
        vecs[4] = mkv(1, 0, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FF80, 0, 3,
                      pat(32'hFFFF_FF80, 0), pat(32'hFFFF_FF80, 1));
        vecs[5] = mkv(1, 1, 32'h4321_00C5, 32'h2FF, pb, 32'h4321_0080, 32'h280, 4,
                      pat(32'h4321_0080, 0), pat(32'h4321_0080, 1));
        vecs[6] = mkv(0, 0, 32'h280, 0, 0, 32'h280, 0, 3, pb, pat(32'h280, 1));

        rst_n = 1'b0;
        req0 = 0; req1 = 0; wb1 = 0; halt_req = 0;
        addr0 = 0; addr1 = 0; wb_addr1 = 0; wdata1 = 0;
        r4_req0 = 0; r4_addr0 = 0;
        mif4.mem_out1 = '0;
        mif4.mem_out2 = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 7; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Both ports held from reset: alternate 0,1,0,1.
        @(negedge clk);
        rst_n = 1'b0;
        req0 = 1; req1 = 1; wb1 = 0;
        addr0 = 32'h1000; addr1 = 32'h2000;
        sb.push_back('{port: 1'b0, lo: pat(32'h1000, 0), hi: pat(32'h1000, 1)});
        sb.push_back('{port: 1'b1, lo: pat(32'h2000, 0), hi: pat(32'h2000, 1)});
        sb.push_back('{port: 1'b0, lo: pat(32'h1000, 0), hi: pat(32'h1000, 1)});
        sb.push_back('{port: 1'b1, lo: pat(32'h2000, 0), hi: pat(32'h2000, 1)});
        @(negedge clk);
        rst_n = 1'b1;
        n_start = n_done;
        c_end = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (n_done - n_start >= 4) begin
                req0 = 0;
                req1 = 0;
                c_end = c + 1;
                break;
            end
        end
        req0 = 0;
        req1 = 0;
        chk("rr_cycles", c_end, 12);
        repeat (6) @(negedge clk);
        chk("rr_total_done", n_done - n_start, 4);
        @(posedge clk);
        #1;

        // LAT=4 instance: only the value at the last WAIT edge is captured.
        r4_req0 = 1;
        r4_addr0 = 32'h0000_0345;
        @(posedge clk);
        #1;
        c_end = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk("lat4_rd", mif4.mem_readable, 1);
                chk("lat4_addr", mif4.mem_addr, 32'h0000_0300);
            end
            if (d4_done0) begin
                c_end = c;
                chk("lat4_lo", d4_lo, {16{32'hC000_0005}});
                chk("lat4_hi", d4_hi, {16{32'hD000_0005}});
                chk("lat4_d1", d4_done1, 0);
                r4_req0 = 0;
                break;
            end
            mif4.mem_out1 = {16{32'hC000_0000 | 32'(c)}};
            mif4.mem_out2 = {16{32'hD000_0000 | 32'(c)}};
        end
        r4_req0 = 0;
        chk("lat4_latency", c_end, 6);
        @(negedge clk);
        chk("lat4_no_dup", d4_done0, 0);
        @(posedge clk);
        #1;

        // Halt raised during a port 1 WAIT with port 0 pending.
        sb.push_back('{port: 1'b1, lo: pat(32'h600, 0), hi: pat(32'h600, 1)});
        req1 = 1; addr1 = 32'h600; wb1 = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        @(negedge clk);
        chk("halt_wait_rd", mif.mem_readable, 0);
        halt_req = 1;
        req0 = 1;
        addr0 = 32'h700;
        @(negedge clk);
        chk("halt_done1", done1, 1);
        chk("halt_c3_flush", mif.mem_flush, 0);
        chk("halt_c3_halted", halted, 0);
        req1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("halt_flush", mif.mem_flush, 1);
            chk("halt_halted", halted, 1);
            chk("halt_rd", mif.mem_readable, 0);
            chk("halt_done0", done0, 0);
        end
        halt_req = 0;
        @(negedge clk);
        chk("halt_sticky", halted, 1);
        req0 = 0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("halt_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset pulsed during READ aborts with no done.
        req0 = 1;
        addr0 = 32'h900;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mid_rd", mif.mem_readable, 1);
        chk("mid_addr", mif.mem_addr, 32'h900);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("mid_rst");
        req0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        do_txn(mkv(0, 0, 32'h940, 0, 0, 32'h900, 0, 3,
                   pat(32'h900, 0), pat(32'h900, 1)), "post_rst");
        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
